// File: rtl/seq001_det_arbiter_pkg.sv
// Shared encodings and default sizes for the round-robin "001" detector arbiter.
package seq001_det_arbiter_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_ID_W   = 2;
    localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/seq001_det_arbiter_if.sv
// Client-side bus of the detector arbiter: job requests in, grants and results out.
interface seq001_det_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] word_in;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    done;
    logic [ID_W-1:0]         done_id;
    logic [CNT_W-1:0]        match_cnt;

    modport master (
        output req, word_in,
        input  gnt, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, word_in,
        output gnt, busy, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq001_det.sv
// Moore "001" serial detector; det is high only in S3, the state reached right after a 0,0,1 run.
import seq001_det_arbiter_pkg::*;

module seq001_det (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inp,
    output logic det
);
    det_state_t state, state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S0: state_nxt = inp ? S0 : S1;
            S1: state_nxt = inp ? S0 : S2;
            S2: state_nxt = inp ? S3 : S2;
            S3: state_nxt = inp ? S0 : S1;
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr)
            state <= S0;
        else
            state <= state_nxt;
    end

    assign det = (state == S3);

endmodule

// File: rtl/seq001_det_arbiter.sv
// Round-robin arbiter that feeds one granted word at a time, MSB-first, into a shared
// "001" detector and reports the saturating match count with the requester index.
import seq001_det_arbiter_pkg::*;

module seq001_det_arbiter #(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int ID_W   = DEF_ID_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    seq001_det_arbiter_if.slave  bus
);
    localparam int BIT_W = $clog2(WORD_W + 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, id, winner;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_c;
    logic              grant, det;
    logic              done_r;
    logic [ID_W-1:0]   done_id_r;
    logic [CNT_W-1:0]  match_cnt_r;

    // First set request at or after ptr, searching upward and wrapping.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && r[ID_W'(idx)]) begin
                w     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = rr_pick(bus.req, rr_ptr);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_c     = '0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!reset && (bus.req != '0)) begin
                    grant         = 1'b1;
                    gnt_c[winner] = 1'b1;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT:   if (bitcnt == BIT_W'(WORD_W - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state == SHIFT || state == DRAIN) && det && (cnt != {CNT_W{1'b1}}))
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id          <= '0;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            done_r      <= 1'b0;
            done_id_r   <= '0;
            match_cnt_r <= '0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == DRAIN);
            if (grant) begin
                shreg  <= bus.word_in[int'(winner)*WORD_W +: WORD_W];
                id     <= winner;
                rr_ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                cnt    <= '0;
                bitcnt <= '0;
            end else begin
                cnt <= cnt_nxt;
                if (state == SHIFT) begin
                    shreg  <= {shreg[WORD_W-2:0], 1'b0};
                    bitcnt <= bitcnt + 1'b1;
                end
            end
            // DRAIN's own detection is folded in via cnt_nxt so DONE shows the final count.
            if (state == DRAIN) begin
                done_id_r   <= id;
                match_cnt_r <= cnt_nxt;
            end
        end
    end

    // Clearing at the grant edge keeps detector history from leaking between jobs.
    seq001_det u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (grant),
        .inp   (shreg[WORD_W-1]),
        .det   (det)
    );

    assign bus.gnt       = gnt_c;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.done_id   = done_id_r;
    assign bus.match_cnt = match_cnt_r;

endmodule

// File: tb/tb_seq001_det_arbiter.sv
// Directed bench for seq001_det_arbiter: default 4x8 instance plus a 48-bit/3-bit saturation instance.
module tb_seq001_det_arbiter;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    seq001_det_arbiter_if #(.N_REQ(4), .WORD_W(8), .ID_W(2), .CNT_W(4)) dut_if ();
    seq001_det_arbiter_if #(.N_REQ(4), .WORD_W(48), .ID_W(2), .CNT_W(3)) sat_if ();

    seq001_det_arbiter #(.N_REQ(4), .WORD_W(8), .ID_W(2), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    seq001_det_arbiter #(.N_REQ(4), .WORD_W(48), .ID_W(2), .CNT_W(3)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] words);
        dut_if.req     = r;
        dut_if.word_in = words;
    endtask

    // Issue one job from IDLE (called at posedge+1) and follow it to the IDLE cycle after DONE.
    task automatic runJob(input string tag, input logic [3:0] r, input logic [31:0] words,
                          input int exp_w, input int exp_cnt, input bit hold, output int gnt_cycle);
        int lat;
        applyStimulus(r, words);
        #1;
        checkOutput({tag, "_gnt"}, 64'(dut_if.gnt), 64'(4'b0001 << exp_w));
        gnt_cycle = cycle;
        @(posedge clk); #1;
        if (!hold) dut_if.req = '0;
        dut_if.word_in = ~words;
        checkOutput({tag, "_busy"}, 64'(dut_if.busy), 64'd1);
        checkOutput({tag, "_gnt_shift"}, 64'(dut_if.gnt), 64'd0);
        lat = 1;
        while (!dut_if.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd10);
        checkOutput({tag, "_done_id"}, 64'(dut_if.done_id), 64'(exp_w));
        checkOutput({tag, "_match_cnt"}, 64'(dut_if.match_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        checkOutput({tag, "_done_low"}, 64'(dut_if.done), 64'd0);
        checkOutput({tag, "_cnt_hold"}, 64'(dut_if.match_cnt), 64'(exp_cnt));
        dut_if.word_in = words;
    endtask

    initial begin
        int g_prev, g_now, lat, pulses;
        reset          = 1'b1;
        dut_if.req     = 4'b1111;
        dut_if.word_in = '0;
        sat_if.req     = '0;
        sat_if.word_in = '0;
        $display("[TB] reset phase");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 64'(dut_if.gnt), 64'd0);
        checkOutput("rst_busy", 64'(dut_if.busy), 64'd0);
        checkOutput("rst_done", 64'(dut_if.done), 64'd0);
        checkOutput("rst_done_id", 64'(dut_if.done_id), 64'd0);
        checkOutput("rst_match_cnt", 64'(dut_if.match_cnt), 64'd0);
        dut_if.req = '0;
        reset      = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single requester");
        runJob("single", 4'b0001, {24'h0, 8'b00100100}, 0, 2, 1'b0, g_now);

        $display("[TB] edge patterns on requester 2");
        runJob("ff",    4'b0100, {8'h0, 8'hFF, 16'h0},       2, 0, 1'b0, g_now);
        runJob("last1", 4'b0100, {8'h0, 8'b00000001, 16'h0}, 2, 1, 1'b0, g_now);
        runJob("two",   4'b0100, {8'h0, 8'b00010001, 16'h0}, 2, 2, 1'b0, g_now);

        $display("[TB] wrap and skip from pointer 3");
        runJob("wrap0", 4'b0101, {8'h0, 8'hFF, 8'h0, 8'b00100100}, 0, 2, 1'b1, g_now);
        runJob("wrap2", 4'b0101, {8'h0, 8'hFF, 8'h0, 8'b00100100}, 2, 0, 1'b0, g_now);

        runJob("align3", 4'b1000, {8'b10010010, 24'h0}, 3, 2, 1'b0, g_now);

        $display("[TB] round-robin fairness");
        runJob("rr0", 4'b1111, {8'b00010001, 8'b00000001, 8'hFF, 8'b00100100}, 0, 2, 1'b1, g_prev);
        runJob("rr1", 4'b1111, {8'b00010001, 8'b00000001, 8'hFF, 8'b00100100}, 1, 0, 1'b1, g_now);
        checkOutput("rr_space01", 64'(g_now - g_prev), 64'd11);
        g_prev = g_now;
        runJob("rr2", 4'b1111, {8'b00010001, 8'b00000001, 8'hFF, 8'b00100100}, 2, 1, 1'b1, g_now);
        checkOutput("rr_space12", 64'(g_now - g_prev), 64'd11);
        g_prev = g_now;
        runJob("rr3", 4'b1111, {8'b00010001, 8'b00000001, 8'hFF, 8'b00100100}, 3, 2, 1'b1, g_now);
        checkOutput("rr_space23", 64'(g_now - g_prev), 64'd11);
        g_prev = g_now;
        runJob("rr0b", 4'b1111, {8'b00010001, 8'b00000001, 8'hFF, 8'b00100100}, 0, 2, 1'b0, g_now);
        checkOutput("rr_space30", 64'(g_now - g_prev), 64'd11);

        $display("[TB] reset mid-job");
        applyStimulus(4'b0010, {16'h0, 8'b00000000, 8'h0});
        @(posedge clk); #1;
        dut_if.req = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_in_shift", 64'(dut_if.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_busy", 64'(dut_if.busy), 64'd0);
        checkOutput("abort_match_cnt", 64'(dut_if.match_cnt), 64'd0);
        checkOutput("abort_done_id", 64'(dut_if.done_id), 64'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dut_if.done) pulses++;
        end
        checkOutput("abort_no_done", 64'(pulses), 64'd0);
        runJob("after_abort", 4'b0010, {16'h0, 8'b01001001, 8'h0}, 1, 2, 1'b0, g_now);

        $display("[TB] saturation instance");
        sat_if.word_in = {144'h0, {16{3'b001}}};
        sat_if.req     = 4'b0001;
        #1;
        checkOutput("sat_gnt", 64'(sat_if.gnt), 64'd1);
        @(posedge clk); #1;
        sat_if.req = '0;
        lat = 1;
        while (!sat_if.done && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("sat_latency", 64'(lat), 64'd50);
        checkOutput("sat_done_id", 64'(sat_if.done_id), 64'd0);
        checkOutput("sat_match_cnt", 64'(sat_if.match_cnt), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq001_det_arbiter.md
Name: seq001_det_arbiter

Overview:
- Shares one Moore "001" serial sequence detector between N_REQ requesters.
- Each requester presents a parallel word and the block grants one requester round-robin.
- The granted word is shifted MSB-first into the detector, and the count of completed "001" detections is reported with the requester ID.
- Sits between word-producing clients and the single detector instance; it is the detector's only driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per job word, shifted MSB-first.
- ID_W, 2, width of requester index; must equal clog2(N_REQ).
- CNT_W, 4, match counter width; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester job request, level; bit i = requester i.
- word_in  input  N_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- gnt  output  N_REQ  one-hot, one-cycle acceptance pulse; word captured at that edge.
- busy  output  1  high from the cycle after a grant until DONE completes.
- done  output  1  one-cycle pulse; done_id and match_cnt are valid while it is high.
- done_id  output  ID_W  index of the requester whose job finished.
- match_cnt  output  CNT_W  number of "001" detections in the job word.

Behaviour:
- Reset, checked at the clock edge:
  - FSM goes to IDLE, rr_ptr=0, done=0, busy=0, done_id=0, match_cnt=0; gnt is 0 while reset is high.
  - The detector is forced to its initial state.
  - Reset mid-job aborts the job: no done pulse, and the word is discarded.
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - If req!=0, gnt is asserted combinationally for winner w. The winner is the first set req bit at or after rr_ptr, searching upward with wrap.
  - At the edge: shreg<=word_in[w], id<=w, rr_ptr<=(w+1) mod N_REQ, detector cleared to initial state, cnt<=0, bitcnt<=0, next state SHIFT.
  - If req==0, stay in IDLE.
- SHIFT:
  - Detector input = shreg[WORD_W-1]; each edge shifts shreg left by one and increments bitcnt.
  - After WORD_W cycles, go to DRAIN.
- DRAIN: one cycle so that the Moore detector output for the last bit can be sampled. Next state DONE.
- Counting:
  - In every SHIFT and DRAIN cycle where det==1, cnt increments, saturating at 2^CNT_W-1.
  - det in the first SHIFT cycle is 0 because of the clear.
- DONE:
  - done=1, done_id=id, match_cnt=cnt, all registered.
  - Next state is IDLE; no grant is issued in the DONE cycle.
  - done_id and match_cnt hold their values until the next DONE.
- Timing: grant in cycle t → SHIFT cycles t+1..t+WORD_W → DRAIN at t+WORD_W+1 → done at t+WORD_W+2. The earliest next grant is t+WORD_W+3.
- busy=1 in SHIFT, DRAIN and DONE.
- Detector semantics, states s0..s3, det=1 only in s3:
  - s0: 1→s0, 0→s1.
  - s1: 1→s0, 0→s2.
  - s2: 1→s3, 0→s2.
  - s3: 1→s0, 0→s1.
  - Consequences: a run of extra leading zeros still gives one match; a trailing 0 after a match can begin the next match.
- The detector state never carries across jobs; it is cleared at every grant.
- A req deasserted after its grant has no effect. A requester holding req continuously is re-eligible after DONE but waits behind other pending requesters, per rr_ptr.
- word_in is sampled only at the grant edge; changes at other times are ignored.

Decomposition:
- Shared package:
  - detector state encoding S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11;
  - arbiter FSM encoding IDLE/SHIFT/DRAIN/DONE;
  - default WORD_W/CNT_W constants.
- One sub-module, seq001_det:
  - ports clk, reset, clr, inp, det;
  - synchronous clear has priority over the state update;
  - Moore output decoded from the state register only.
- The round-robin picker is kept inline as a function, not a separate module.

Test Plan:
- Single requester: req=4'b0001, word0=8'b00100100 → gnt=0001 at t, done at t+10, done_id=0, match_cnt=2.
- Edge patterns, one at a time on requester 2:
  - 8'hFF → match_cnt=0;
  - 8'b00000001 → match_cnt=1 (pattern completes on the last bit, so DRAIN sampling is exercised);
  - 8'b00010001 → 2.
- Round-robin fairness: req=4'b1111 held → grant order 0,1,2,3,0; gnts spaced 11 cycles apart; done_id matches each grant.
- Wrap and skip: rr_ptr=3, req=4'b0101 → requester 0 granted, then 2; requester 1 and 3 never granted.
- Reset mid-job: assert reset in SHIFT cycle 4 → no done pulse, outputs return to 0. The next job (word 8'b01001001) yields match_cnt=2 with no contamination from the aborted job.
- Saturation: WORD_W=48, CNT_W=3, word of sixteen repeats of "001" → match_cnt=7.
